// File: rtl/l2_bus_pkg.sv
// Shared types and opcode decoding for the L2 bus request decoder.
// Opcodes arrive as ASCII: two characters on the L1 bus, one on the snoop bus.
package l2_bus_pkg;

   typedef enum logic [2:0] {
      CMD_DR = 3'd0,
      CMD_DW = 3'd1,
      CMD_IR = 3'd2,
      CMD_SI = 3'd3,
      CMD_SR = 3'd4,
      CMD_SW = 3'd5,
      CMD_SM = 3'd6
   } cmd_t;

   typedef struct packed {
      logic ok;
      cmd_t cmd;
   } decode_t;

   localparam logic [15:0] OP_L1_DR = 16'h4452;
   localparam logic [15:0] OP_L1_DW = 16'h4457;
   localparam logic [15:0] OP_L1_IR = 16'h4952;
   localparam logic [7:0]  OP_SN_I  = 8'h49;
   localparam logic [7:0]  OP_SN_R  = 8'h52;
   localparam logic [7:0]  OP_SN_W  = 8'h57;
   localparam logic [7:0]  OP_SN_M  = 8'h4D;

   function automatic decode_t decode_l1(input logic [15:0] op);
      decode_t d;
      d.ok  = 1'b1;
      d.cmd = CMD_DR;
      case (op)
         OP_L1_DR: d.cmd = CMD_DR;
         OP_L1_DW: d.cmd = CMD_DW;
         OP_L1_IR: d.cmd = CMD_IR;
         default: begin
            d.ok  = 1'b0;
            d.cmd = CMD_DR;
         end
      endcase
      return d;
   endfunction

   function automatic decode_t decode_snoop(input logic [7:0] op);
      decode_t d;
      d.ok  = 1'b1;
      d.cmd = CMD_SI;
      case (op)
         OP_SN_I: d.cmd = CMD_SI;
         OP_SN_R: d.cmd = CMD_SR;
         OP_SN_W: d.cmd = CMD_SW;
         OP_SN_M: d.cmd = CMD_SM;
         default: begin
            d.ok  = 1'b0;
            d.cmd = CMD_SI;
         end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/l2_req_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a pop in the same cycle frees a
// slot so a push into a full queue still succeeds.
module l2_req_fifo
   import l2_bus_pkg::*;
#(
   parameter int width = 35,
   parameter int depth = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [width-1:0] push_data,
   input  logic             pop,
   output logic [width-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(depth);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic [width-1:0] mem_r [depth];
   logic             do_pop_s;
   logic             do_push_s;

   assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign do_pop_s  = pop && !empty;
   assign do_push_s = push && (!full || do_pop_s);
   assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];

   // Pointer update
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         else           wr_ptr_r <= wr_ptr_r;
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         else           rd_ptr_r <= rd_ptr_r;
      end
   end

   // Storage write; contents are qualified by the pointers so need no reset
   always_ff @(posedge clk) begin
      if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/l2_bus_request_decoder.sv
// Decodes L1 and snoop bus requests into per-channel queues and presents them
// to the L2 controller through a single valid/ready holding register.
module l2_bus_request_decoder
   import l2_bus_pkg::*;
#(
   parameter int stats       = 1,
   parameter int addressSize = 32,
   parameter int fifoDepth   = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   l1_valid,
   input  logic [addressSize-1:0] l1_address,
   input  logic [15:0]            l1_operation,
   input  logic                   snoop_valid,
   input  logic [addressSize-1:0] snoop_address,
   input  logic [7:0]             snoop_operation,
   output logic                   req_valid,
   input  logic                   req_ready,
   output logic [2:0]             req_cmd,
   output logic [addressSize-1:0] req_address,
   output logic                   req_is_snoop,
   output logic                   decode_error,
   output logic                   overflow,
   output logic [31:0]            l1_count,
   output logic [31:0]            snoop_count
);

   localparam int ENTRY_W = 3 + addressSize;

   decode_t            l1_dec_s;
   decode_t            snoop_dec_s;
   logic               l1_push_s;
   logic               snoop_push_s;
   logic               l1_accept_s;
   logic               snoop_accept_s;
   logic               l1_full_s;
   logic               l1_empty_s;
   logic               snoop_full_s;
   logic               snoop_empty_s;
   logic               l1_pop_s;
   logic               snoop_pop_s;
   logic               load_s;
   logic [ENTRY_W-1:0] l1_entry_s;
   logic [ENTRY_W-1:0] snoop_entry_s;
   logic [ENTRY_W-1:0] l1_head_s;
   logic [ENTRY_W-1:0] snoop_head_s;

   assign l1_dec_s      = decode_l1(l1_operation);
   assign snoop_dec_s   = decode_snoop(snoop_operation);
   assign l1_push_s     = l1_valid && l1_dec_s.ok;
   assign snoop_push_s  = snoop_valid && snoop_dec_s.ok;
   assign l1_entry_s    = {l1_dec_s.cmd, l1_address};
   assign snoop_entry_s = {snoop_dec_s.cmd, snoop_address};

   // Mirrors the FIFO's own acceptance rule so drops and counts stay consistent
   assign l1_accept_s    = l1_push_s && (!l1_full_s || l1_pop_s);
   assign snoop_accept_s = snoop_push_s && (!snoop_full_s || snoop_pop_s);

   l2_req_fifo #(.width(ENTRY_W), .depth(fifoDepth)) u_l1_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (l1_push_s),
      .push_data (l1_entry_s),
      .pop       (l1_pop_s),
      .pop_data  (l1_head_s),
      .full      (l1_full_s),
      .empty     (l1_empty_s)
   );

   l2_req_fifo #(.width(ENTRY_W), .depth(fifoDepth)) u_snoop_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (snoop_push_s),
      .push_data (snoop_entry_s),
      .pop       (snoop_pop_s),
      .pop_data  (snoop_head_s),
      .full      (snoop_full_s),
      .empty     (snoop_empty_s)
   );

   // Arbiter: refill the stage when it is free, snoop queue first
   always_comb begin
      load_s      = !req_valid || req_ready;
      l1_pop_s    = 1'b0;
      snoop_pop_s = 1'b0;
      if (load_s) begin
         if (!snoop_empty_s) begin
            snoop_pop_s = 1'b1;
         end else if (!l1_empty_s) begin
            l1_pop_s = 1'b1;
         end else begin
            l1_pop_s    = 1'b0;
            snoop_pop_s = 1'b0;
         end
      end else begin
         l1_pop_s    = 1'b0;
         snoop_pop_s = 1'b0;
      end
   end

   // Output holding register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_valid    <= 1'b0;
         req_cmd      <= 3'd0;
         req_address  <= {addressSize{1'b0}};
         req_is_snoop <= 1'b0;
      end else if (snoop_pop_s) begin
         req_valid    <= 1'b1;
         req_cmd      <= snoop_head_s[ENTRY_W-1 -: 3];
         req_address  <= snoop_head_s[addressSize-1:0];
         req_is_snoop <= 1'b1;
      end else if (l1_pop_s) begin
         req_valid    <= 1'b1;
         req_cmd      <= l1_head_s[ENTRY_W-1 -: 3];
         req_address  <= l1_head_s[addressSize-1:0];
         req_is_snoop <= 1'b0;
      end else if (load_s) begin
         req_valid    <= 1'b0;
      end else begin
         req_valid    <= req_valid;
      end
   end

   // Error and drop pulses, one cycle after the offending strobe
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         decode_error <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         decode_error <= (l1_valid && !l1_dec_s.ok) || (snoop_valid && !snoop_dec_s.ok);
         overflow     <= (l1_push_s && !l1_accept_s) || (snoop_push_s && !snoop_accept_s);
      end
   end

   // Per-channel accepted-request statistics
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         l1_count    <= 32'd0;
         snoop_count <= 32'd0;
      end else if (stats != 0) begin
         if (l1_accept_s) l1_count <= l1_count + 32'd1;
         else             l1_count <= l1_count;
         if (snoop_accept_s) snoop_count <= snoop_count + 32'd1;
         else                snoop_count <= snoop_count;
      end else begin
         l1_count    <= 32'd0;
         snoop_count <= 32'd0;
      end
   end

endmodule

// File: tb/tb_l2_bus_request_decoder.sv
// Randomized and directed bench for l2_bus_request_decoder against a
// queue-based reference model of the request path.
module tb_l2_bus_request_decoder;

   localparam int AS = 32;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          l1_valid = 1'b0;
   logic [AS-1:0] l1_address = '0;
   logic [15:0]   l1_operation = '0;
   logic          snoop_valid = 1'b0;
   logic [AS-1:0] snoop_address = '0;
   logic [7:0]    snoop_operation = '0;
   logic          req_ready = 1'b0;
   logic          req_valid;
   logic [2:0]    req_cmd;
   logic [AS-1:0] req_address;
   logic          req_is_snoop;
   logic          decode_error;
   logic          overflow;
   logic [31:0]   l1_count;
   logic [31:0]   snoop_count;

   always #5 clk = ~clk;

   l2_bus_request_decoder #(.stats(1), .addressSize(AS), .fifoDepth(FD)) dut (
      .clk             (clk),
      .reset           (reset),
      .l1_valid        (l1_valid),
      .l1_address      (l1_address),
      .l1_operation    (l1_operation),
      .snoop_valid     (snoop_valid),
      .snoop_address   (snoop_address),
      .snoop_operation (snoop_operation),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_cmd         (req_cmd),
      .req_address     (req_address),
      .req_is_snoop    (req_is_snoop),
      .decode_error    (decode_error),
      .overflow        (overflow),
      .l1_count        (l1_count),
      .snoop_count     (snoop_count)
   );

   typedef struct {
      logic [2:0]    cmd;
      logic [AS-1:0] addr;
   } ent_t;

   int checks = 0;
   int errors = 0;

   ent_t          l1_q[$];
   ent_t          sn_q[$];
   bit            m_valid;
   ent_t          m_ent;
   bit            m_snoop;
   bit            m_err;
   bit            m_ovf;
   logic [31:0]   m_l1_cnt;
   logic [31:0]   m_sn_cnt;
   logic [AS-1:0] xfer_q[$];
   int            ovf_seen;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int l1_code(input logic [15:0] op);
      if (op == "DR") return 0;
      if (op == "DW") return 1;
      if (op == "IR") return 2;
      return -1;
   endfunction

   function automatic int snoop_code(input logic [7:0] op);
      if (op == "I") return 3;
      if (op == "R") return 4;
      if (op == "W") return 5;
      if (op == "M") return 6;
      return -1;
   endfunction

   task automatic model_reset();
      l1_q.delete();
      sn_q.delete();
      m_valid  = 1'b0;
      m_snoop  = 1'b0;
      m_err    = 1'b0;
      m_ovf    = 1'b0;
      m_l1_cnt = 32'd0;
      m_sn_cnt = 32'd0;
   endtask

   // One rising edge of the model: free stage takes a queue head (snoop first),
   // then the sampled strobes enqueue behind whatever was just removed.
   task automatic model_edge();
      int code;
      if (!m_valid || req_ready) begin
         if (sn_q.size() > 0) begin
            m_ent = sn_q.pop_front(); m_snoop = 1'b1; m_valid = 1'b1;
         end else if (l1_q.size() > 0) begin
            m_ent = l1_q.pop_front(); m_snoop = 1'b0; m_valid = 1'b1;
         end else begin
            m_valid = 1'b0;
         end
      end
      m_err = 1'b0;
      m_ovf = 1'b0;
      if (l1_valid) begin
         code = l1_code(l1_operation);
         if (code < 0) m_err = 1'b1;
         else if (l1_q.size() < FD) begin
            l1_q.push_back('{cmd: 3'(code), addr: l1_address});
            m_l1_cnt++;
         end else m_ovf = 1'b1;
      end
      if (snoop_valid) begin
         code = snoop_code(snoop_operation);
         if (code < 0) m_err = 1'b1;
         else if (sn_q.size() < FD) begin
            sn_q.push_back('{cmd: 3'(code), addr: snoop_address});
            m_sn_cnt++;
         end else m_ovf = 1'b1;
      end
   endtask

   task automatic compare_outputs();
      check_value("req_valid", req_valid, m_valid);
      if (m_valid) begin
         check_value("req_cmd", req_cmd, m_ent.cmd);
         check_value("req_address", req_address, m_ent.addr);
         check_value("req_is_snoop", req_is_snoop, m_snoop);
      end
      check_value("decode_error", decode_error, m_err);
      check_value("overflow", overflow, m_ovf);
      check_value("l1_count", l1_count, m_l1_cnt);
      check_value("snoop_count", snoop_count, m_sn_cnt);
   endtask

   // Inputs are set at the falling edge before calling; outputs checked at the next falling edge
   task automatic step();
      if (req_valid && req_ready) xfer_q.push_back(req_address);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (overflow) ovf_seen++;
      compare_outputs();
   endtask

   task automatic idle();
      l1_valid    = 1'b0;
      snoop_valid = 1'b0;
   endtask

   // Asserts reset between edges and checks that outputs clear without a clock
   task automatic apply_reset();
      idle();
      #2 reset = 1'b1;
      #1;
      check_value("rst_valid", req_valid, 1'b0);
      check_value("rst_cmd", req_cmd, 3'd0);
      check_value("rst_addr", req_address, 32'd0);
      check_value("rst_snoop", req_is_snoop, 1'b0);
      check_value("rst_err", decode_error, 1'b0);
      check_value("rst_ovf", overflow, 1'b0);
      check_value("rst_l1_count", l1_count, 32'd0);
      check_value("rst_snoop_count", snoop_count, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      xfer_q.delete();
      ovf_seen = 0;
   endtask

   initial begin
      logic [15:0] l1_op;
      logic [7:0]  sn_op;
      model_reset();
      ovf_seen = 0;
      @(negedge clk);
      apply_reset();

      // Single read: two edges of latency
      req_ready = 1'b1;
      l1_valid = 1'b1; l1_operation = "DR"; l1_address = 32'h0000_1A40;
      step(); idle();
      check_value("read_not_yet", req_valid, 1'b0);
      step();
      check_value("read_valid", req_valid, 1'b1);
      check_value("read_cmd", req_cmd, 3'd0);
      check_value("read_addr", req_address, 32'h0000_1A40);
      check_value("read_snoop", req_is_snoop, 1'b0);
      check_value("read_l1_count", l1_count, 32'd1);
      step();

      // Snoop priority over a same-cycle L1 request
      apply_reset();
      req_ready = 1'b1;
      l1_valid = 1'b1; l1_operation = "DW"; l1_address = 32'h100;
      snoop_valid = 1'b1; snoop_operation = "M"; snoop_address = 32'h200;
      step(); idle();
      step();
      check_value("prio_first_cmd", req_cmd, 3'd6);
      check_value("prio_first_addr", req_address, 32'h200);
      check_value("prio_first_snoop", req_is_snoop, 1'b1);
      step();
      check_value("prio_second_cmd", req_cmd, 3'd1);
      check_value("prio_second_addr", req_address, 32'h100);
      step(); step();

      // Stall: held L1 entry is not pre-empted by a later snoop
      apply_reset();
      req_ready = 1'b0;
      l1_valid = 1'b1; l1_operation = "DR"; l1_address = 32'h300;
      step(); idle();
      step();
      snoop_valid = 1'b1; snoop_operation = "I"; snoop_address = 32'h400;
      step(); idle();
      repeat (3) step();
      check_value("stall_cmd", req_cmd, 3'd0);
      check_value("stall_addr", req_address, 32'h300);
      req_ready = 1'b1;
      repeat (4) step();
      check_value("stall_xfers", xfer_q.size(), 2);
      if (xfer_q.size() == 2) begin
         check_value("stall_first", xfer_q[0], 32'h300);
         check_value("stall_second", xfer_q[1], 32'h400);
      end

      // Overflow: stage plus a full queue absorb five of six pushes
      apply_reset();
      req_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         l1_valid = 1'b1; l1_operation = "IR"; l1_address = 32'h1000 + 32'(i * 4);
         step();
      end
      idle();
      step();
      check_value("ovf_pulses", ovf_seen, 1);
      check_value("ovf_l1_count", l1_count, 32'd5);
      req_ready = 1'b1;
      repeat (8) step();
      check_value("ovf_drained", xfer_q.size(), 5);
      for (int i = 0; i < 5 && i < xfer_q.size(); i++)
         check_value("ovf_order", xfer_q[i], 32'h1000 + 32'(i * 4));

      // Unknown opcode
      apply_reset();
      req_ready = 1'b1;
      l1_valid = 1'b1; l1_operation = "XX"; l1_address = 32'h600;
      step(); idle();
      check_value("bad_err", decode_error, 1'b1);
      check_value("bad_count", l1_count, 32'd0);
      step();
      check_value("bad_err_clear", decode_error, 1'b0);
      check_value("bad_no_valid", req_valid, 1'b0);

      // Reset while a request is stalled
      apply_reset();
      req_ready = 1'b0;
      l1_valid = 1'b1; l1_operation = "DR"; l1_address = 32'h500;
      step(); idle();
      step();
      check_value("mid_valid", req_valid, 1'b1);
      apply_reset();
      repeat (3) step();
      check_value("mid_no_stale", req_valid, 1'b0);

      // Random traffic with phases of backpressure
      apply_reset();
      for (int i = 0; i < 800; i++) begin
         if (i == 400) apply_reset();
         case ($urandom_range(0, 4))
            0: l1_op = "DR";
            1: l1_op = "DW";
            2: l1_op = "IR";
            3: l1_op = 16'($urandom);
            default: l1_op = "XX";
         endcase
         case ($urandom_range(0, 5))
            0: sn_op = "I";
            1: sn_op = "R";
            2: sn_op = "W";
            3: sn_op = "M";
            4: sn_op = 8'($urandom);
            default: sn_op = "Z";
         endcase
         l1_valid        = ($urandom_range(0, 1) == 1);
         l1_operation    = l1_op;
         l1_address      = $urandom;
         snoop_valid     = ($urandom_range(0, 2) == 0);
         snoop_operation = sn_op;
         snoop_address   = $urandom;
         if (((i / 40) % 3) == 0) req_ready = ($urandom_range(0, 4) == 0);
         else                     req_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      idle();
      req_ready = 1'b1;
      repeat (12) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
